// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: pops A/B/opcode frames from the UART rx FIFO, runs them through the ALU, pushes the result byte to tx.
module uart_alu_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TMO_CYC = 50000000,
  parameter int NB_TMO  = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [NB_DATA-1:0] r_data,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [NB_DATA-1:0] w_data,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  input  logic [NB_DATA-1:0] alu_result,
  output logic               busy,
  output logic               frame_err
);
  typedef enum logic [2:0] {S_GET_A, S_GET_B, S_GET_OP, S_EXEC, S_SEND} state_t;
  state_t state, state_n;
  logic [NB_TMO-1:0] cnt, cnt_n;
  logic [NB_DATA-1:0] res_q;
  logic waiting;
  assign w_data = res_q;
  always_comb begin
    waiting   = state == S_GET_B || state == S_GET_OP;
    rd_uart   = reset && !rx_empty && (state == S_GET_A || waiting);
    wr_uart   = reset && state == S_SEND && !tx_full;
    busy      = state != S_GET_A;
    frame_err = waiting && rx_empty && cnt == NB_TMO'(TMO_CYC - 1);
    cnt_n     = (waiting && rx_empty && !frame_err) ? cnt + NB_TMO'(1) : '0;
    state_n   = S_GET_A;
    case (state)
      S_GET_A:  state_n = rx_empty ? S_GET_A : S_GET_B;
      S_GET_B:  state_n = !rx_empty ? S_GET_OP : frame_err ? S_GET_A : S_GET_B;
      S_GET_OP: state_n = !rx_empty ? S_EXEC : frame_err ? S_GET_A : S_GET_OP;
      S_EXEC:   state_n = S_SEND;
      S_SEND:   state_n = tx_full ? S_SEND : S_GET_A;
      default:  state_n = S_GET_A;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_GET_A;
      cnt    <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      res_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (rd_uart && state == S_GET_A) alu_a <= r_data;
      if (rd_uart && state == S_GET_B) alu_b <= r_data;
      if (rd_uart && state == S_GET_OP) alu_op <= r_data[NB_OP-1:0];
      if (state == S_EXEC) res_q <= alu_result;
    end
  end
endmodule
